// File: rtl/baccarat_pkg.sv
// Shared types and card arithmetic for the baccarat deal controller and datapath.
package baccarat_pkg;

    typedef enum logic [3:0] {
        StStart,
        StP1,
        StD1,
        StP2,
        StD2,
        StEval,
        StP3,
        StBank,
        StD3,
        StResult,
        StDone
    } deal_state_e;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

    // Face cards and tens count as zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= 4'd10) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/baccarat_draw_rule.sv
// Banker third-card rule, used when the player has drawn a third card.
module baccarat_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] v,
    output logic       dealer_draws
);

    always_comb begin
        dealer_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
            4'd3:             dealer_draws = (v != 4'd8);
            4'd4:             dealer_draws = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             dealer_draws = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             dealer_draws = (v >= 4'd6) && (v <= 4'd7);
            default:          dealer_draws = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_deal_ctrl.sv
// Baccarat deal sequencer: card-load strobes, natural/third-card decisions and win lights.
module baccarat_deal_ctrl
    import baccarat_pkg::*;
#(
    parameter bit          AUTO_RESTART = 1'b0,
    parameter int unsigned HOLD_CYCLES  = 4
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       new_round,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       done
);

    localparam int unsigned    CntW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);

    deal_state_e     state_q, state_d;
    logic [CntW-1:0] hold_q;
    logic [3:0]      pcard3_value;
    logic            dealer_draws;
    logic            natural;

    assign pcard3_value = card_value(pcard3);
    assign natural      = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);

    baccarat_draw_rule u_draw_rule (
        .dscore      (dscore),
        .v           (pcard3_value),
        .dealer_draws(dealer_draws)
    );

    always_comb begin
        state_d = StStart;
        case (state_q)
            // Out of reset START is quiet for one cycle, then pulses new_round.
            StStart:  state_d = new_round ? StP1 : StStart;
            StP1:     state_d = StD1;
            StD1:     state_d = StP2;
            StP2:     state_d = StD2;
            StD2:     state_d = StEval;
            StEval: begin
                if (natural)                             state_d = StResult;
                else if (pscore < PLAYER_STAND_MIN)      state_d = StP3;
                else if (dscore <= 4'd5)                 state_d = StD3;
                else                                     state_d = StResult;
            end
            StP3:     state_d = StBank;
            StBank:   state_d = dealer_draws ? StD3 : StResult;
            StD3:     state_d = StResult;
            StResult: state_d = StDone;
            StDone:   state_d = (AUTO_RESTART && (hold_q == HoldLast)) ? StStart : StDone;
            default:  state_d = StStart;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_q          <= StStart;
            hold_q           <= '0;
            new_round        <= 1'b0;
            load_pcard1      <= 1'b0;
            load_pcard2      <= 1'b0;
            load_pcard3      <= 1'b0;
            load_dcard1      <= 1'b0;
            load_dcard2      <= 1'b0;
            load_dcard3      <= 1'b0;
            done             <= 1'b0;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= (AUTO_RESTART && (state_q == StDone) && (state_d == StDone)) ?
                           hold_q + CntW'(1) : '0;
            new_round   <= (state_d == StStart);
            load_pcard1 <= (state_d == StP1);
            load_dcard1 <= (state_d == StD1);
            load_pcard2 <= (state_d == StP2);
            load_dcard2 <= (state_d == StD2);
            load_pcard3 <= (state_d == StP3);
            load_dcard3 <= (state_d == StD3);
            done        <= (state_d == StDone);
            if (state_d != StDone) begin
                player_win_light <= 1'b0;
                dealer_win_light <= 1'b0;
            end else if (state_q == StResult) begin
                // A tie lights both.
                player_win_light <= (pscore >= dscore);
                dealer_win_light <= (dscore >= pscore);
            end
        end
    end

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Bench for baccarat_deal_ctrl: two instances (hold-in-DONE and auto-restart) with card datapaths.
module tb_baccarat_deal_ctrl;

    localparam logic [9:0] NR  = 10'h200;
    localparam logic [9:0] LP1 = 10'h100;
    localparam logic [9:0] LD1 = 10'h080;
    localparam logic [9:0] LP2 = 10'h040;
    localparam logic [9:0] LD2 = 10'h020;
    localparam logic [9:0] LP3 = 10'h010;
    localparam logic [9:0] LD3 = 10'h008;
    localparam logic [9:0] PW  = 10'h004;
    localparam logic [9:0] DW  = 10'h002;
    localparam logic [9:0] DN  = 10'h001;
    localparam int         HOLD = 4;

    logic slow_clock = 1'b0;
    logic reset = 1'b1;
    always #5 slow_clock = ~slow_clock;

    logic [3:0] pscore [2];
    logic [3:0] dscore [2];
    logic [3:0] pcard3 [2];
    logic [1:0] nr, lp1, lp2, lp3, ld1, ld2, ld3, pw, dw, dn;

    logic [3:0] pc [2][3];
    logic [3:0] dc [2][3];
    logic [3:0] hand [6];  // p1 d1 p2 d2 p3 d3 ranks

    baccarat_deal_ctrl #(.AUTO_RESTART(1'b0), .HOLD_CYCLES(HOLD)) dut0 (
        .slow_clock(slow_clock), .reset(reset),
        .pscore(pscore[0]), .dscore(dscore[0]), .pcard3(pcard3[0]),
        .load_pcard1(lp1[0]), .load_pcard2(lp2[0]), .load_pcard3(lp3[0]),
        .load_dcard1(ld1[0]), .load_dcard2(ld2[0]), .load_dcard3(ld3[0]),
        .new_round(nr[0]), .player_win_light(pw[0]), .dealer_win_light(dw[0]), .done(dn[0])
    );

    baccarat_deal_ctrl #(.AUTO_RESTART(1'b1), .HOLD_CYCLES(HOLD)) dut1 (
        .slow_clock(slow_clock), .reset(reset),
        .pscore(pscore[1]), .dscore(dscore[1]), .pcard3(pcard3[1]),
        .load_pcard1(lp1[1]), .load_pcard2(lp2[1]), .load_pcard3(lp3[1]),
        .load_dcard1(ld1[1]), .load_dcard2(ld2[1]), .load_dcard3(ld3[1]),
        .new_round(nr[1]), .player_win_light(pw[1]), .dealer_win_light(dw[1]), .done(dn[1])
    );

    function automatic int val(input logic [3:0] r);
        return (r >= 4'd10) ? 0 : int'(r);
    endfunction

    // Card-register datapath per instance.
    always @(posedge slow_clock) begin
        for (int i = 0; i < 2; i++) begin
            if (nr[i]) begin
                for (int j = 0; j < 3; j++) begin
                    pc[i][j] <= 4'd0;
                    dc[i][j] <= 4'd0;
                end
            end
            if (lp1[i]) pc[i][0] <= hand[0];
            if (ld1[i]) dc[i][0] <= hand[1];
            if (lp2[i]) pc[i][1] <= hand[2];
            if (ld2[i]) dc[i][1] <= hand[3];
            if (lp3[i]) pc[i][2] <= hand[4];
            if (ld3[i]) dc[i][2] <= hand[5];
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            pscore[k] = 4'((val(pc[k][0]) + val(pc[k][1]) + val(pc[k][2])) % 10);
            dscore[k] = 4'((val(dc[k][0]) + val(dc[k][1]) + val(dc[k][2])) % 10);
            pcard3[k] = pc[k][2];
        end
    end

    function automatic logic [9:0] obs(input int i);
        return {nr[i], lp1[i], ld1[i], lp2[i], ld2[i], lp3[i], ld3[i], pw[i], dw[i], dn[i]};
    endfunction

    // Banker draw table: bit v set means the banker draws on player third-card value v.
    int draw_mask [8] = '{32'h3FF, 32'h3FF, 32'h3FF, 32'h2FF, 32'h0FC, 32'h0F0, 32'h0C0, 32'h000};

    logic [9:0] exp0 [$];
    logic [9:0] exp1 [$];
    int         win_n = 0;
    int         run_id = 0;
    int         lit_done = -1;
    logic       lit_pw = 1'b0;
    logic       lit_dw = 1'b0;

    // Expected per-cycle outputs, starting with the quiet cycle right after reset.
    task automatic build();
        int p, d, v, pf, df;
        bit nat, pdraw, ddraw;
        logic [9:0] body [$];
        logic [9:0] dv;
        p     = (val(hand[0]) + val(hand[2])) % 10;
        d     = (val(hand[1]) + val(hand[3])) % 10;
        v     = val(hand[4]);
        nat   = (p >= 8) || (d >= 8);
        pdraw = !nat && (p <= 5);
        if (nat)        ddraw = 1'b0;
        else if (pdraw) ddraw = draw_mask[d][v];
        else            ddraw = (d <= 5);
        pf = pdraw ? (p + v) % 10 : p;
        df = ddraw ? (d + val(hand[5])) % 10 : d;
        if (pf > df)      dv = DN | PW;
        else if (df > pf) dv = DN | DW;
        else              dv = DN | PW | DW;
        body = '{NR, LP1, LD1, LP2, LD2, 10'h000};
        if (pdraw) begin
            body.push_back(LP3);
            body.push_back(10'h000);
        end
        if (ddraw) body.push_back(LD3);
        body.push_back(10'h000);
        exp0.delete();
        exp1.delete();
        exp0.push_back(10'h000);
        exp1.push_back(10'h000);
        foreach (body[b]) exp0.push_back(body[b]);
        while (exp0.size() < win_n) exp0.push_back(dv);
        while (exp1.size() < win_n) begin
            foreach (body[b]) exp1.push_back(body[b]);
            for (int h = 0; h < HOLD; h++) exp1.push_back(dv);
        end
    endtask

    int total = 0;
    int bad = 0;
    int cur_run = 0;
    int idx = 0;
    int done_at = -1;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s run=%0d cycle=%0d got=%b want=%b", name, run_id, idx, got, want);
        end
    endtask

    // Compare process: every cycle of the current window, both instances against the model.
    initial begin
        forever begin
            @(negedge slow_clock);
            if (cur_run != run_id) begin
                cur_run = run_id;
                idx     = 0;
                done_at = -1;
            end
            if (idx < win_n) begin
                check("outputs_hold", obs(0), exp0[idx]);
                check("outputs_auto", obs(1), exp1[idx]);
                if (done_at < 0 && dn[0]) done_at = idx;
                idx++;
                if (idx == win_n && lit_done >= 0) begin
                    total++;
                    if (done_at != lit_done) begin
                        bad++;
                        $display("FAIL done_latency run=%0d got=%0d want=%0d",
                                 run_id, done_at, lit_done);
                    end
                    total++;
                    if ({pw[0], dw[0]} !== {lit_pw, lit_dw}) begin
                        bad++;
                        $display("FAIL final_lights run=%0d got=%b want=%b",
                                 run_id, {pw[0], dw[0]}, {lit_pw, lit_dw});
                    end
                end
            end
        end
    end

    task automatic run_hand(input logic [3:0] p1, d1, p2, d2, p3, d3,
                            input int w, input int ldone, input logic lpw, input logic ldw);
        hand     = '{p1, d1, p2, d2, p3, d3};
        win_n    = w;
        lit_done = ldone;
        lit_pw   = lpw;
        lit_dw   = ldw;
        build();
        reset = 1'b1;
        @(posedge slow_clock);
        #1;
        reset = 1'b0;
        run_id++;
        repeat (w) @(negedge slow_clock);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge slow_clock);
        #1;
        run_hand(4'd4,  4'd1,  4'd5,  4'd2,  4'd7,  4'd7, 22,  8, 1'b1, 1'b0); // natural 9 v 3
        run_hand(4'd3,  4'd2,  4'd3,  4'd2,  4'd9,  4'd3, 22,  9, 1'b0, 1'b1); // stand 6, banker 4 draws
        run_hand(4'd1,  4'd1,  4'd2,  4'd2,  4'd8,  4'd9, 22, 10, 1'b0, 1'b1); // banker 3, v=8 stands
        run_hand(4'd1,  4'd3,  4'd2,  4'd3,  4'd12, 4'd9, 22, 10, 1'b0, 1'b1); // banker 6, v=0 stands
        run_hand(4'd1,  4'd2,  4'd2,  4'd3,  4'd5,  4'd2, 22, 11, 1'b1, 1'b0); // banker 5, v=5 draws
        run_hand(4'd3,  4'd13, 4'd4,  4'd7,  4'd9,  4'd9, 22,  8, 1'b1, 1'b1); // tie 7-7
        run_hand(4'd2,  4'd4,  4'd2,  4'd4,  4'd1,  4'd1, 22,  8, 1'b0, 1'b1); // dealer natural 8
        run_hand(4'd10, 4'd13, 4'd11, 4'd12, 4'd6,  4'd9, 22, 11, 1'b0, 1'b1); // face cards, both draw
        run_hand(4'd1,  4'd1,  4'd2,  4'd2,  4'd8,  4'd9,  8, -1, 1'b0, 1'b0); // stop in P3
        run_hand(4'd1,  4'd1,  4'd2,  4'd2,  4'd8,  4'd9, 22, 10, 1'b0, 1'b1); // reset there, redeal
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
